load_store_unit: RTL and testbench

- Sits between the ALU/EX stage and the word-addressed data memory; upstream issues byte/halfword/word loads and stores with a valid/ready handshake.
- Translates each request into word-aligned memory strobes and sign/zero-extends load data.
- Performs read-modify-write for sub-word stores, because the memory only writes whole words.
- Flags misaligned and out-of-range accesses without touching memory.

---
 rtl/load_store_unit_pkg.sv | 33 +++
 rtl/load_store_unit_lane_align.sv | 53 +++++
 rtl/load_store_unit.sv | 156 +++++++++++++++
 tb/tb_load_store_unit.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared encodings and helpers for the load/store unit: access sizes, FSM states
// and the request-shape legality check.
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE    = 2'b00,
    SZ_HALF    = 2'b01,
    SZ_WORD    = 2'b10,
    SZ_ILLEGAL = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_READ      = 3'd1,
    ST_WRITE     = 3'd2,
    ST_RMW_READ  = 3'd3,
    ST_RMW_WRITE = 3'd4,
    ST_DONE      = 3'd5
  } state_e;

  // True when the size is illegal or the offset is not naturally aligned for it.
  function automatic logic is_bad_shape(input size_e size, input logic [1:0] offset);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = offset[0];
      SZ_WORD: bad = (offset != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Little-endian lane steering: extracts/extends load data from a memory word and
// merges sub-word store data into an existing word.
module load_store_unit_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  size_e       size,
  input  logic        is_unsigned,
  input  logic [31:0] new_data,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [4:0]  shamt_s;
  logic [31:0] shifted_s;
  logic        sign_s;

  assign shamt_s   = {offset, 3'b000};
  assign shifted_s = word >> shamt_s;

  // Load path: pick the lane and sign- or zero-extend it.
  always_comb begin
    load_data = 32'h0000_0000;
    sign_s    = 1'b0;
    case (size)
      SZ_BYTE: begin
        sign_s    = ~is_unsigned & shifted_s[7];
        load_data = {{24{sign_s}}, shifted_s[7:0]};
      end
      SZ_HALF: begin
        sign_s    = ~is_unsigned & shifted_s[15];
        load_data = {{16{sign_s}}, shifted_s[15:0]};
      end
      SZ_WORD: load_data = shifted_s;
      default: load_data = 32'h0000_0000;
    endcase
  end

  // Store path: replace only the target lane of the old word.
  always_comb begin
    merged_word = word;
    case (size)
      SZ_BYTE: merged_word = (word & ~(32'h0000_00FF << shamt_s))
                           | ((new_data & 32'h0000_00FF) << shamt_s);
      SZ_HALF: merged_word = (word & ~(32'h0000_FFFF << shamt_s))
                           | ((new_data & 32'h0000_FFFF) << shamt_s);
      SZ_WORD: merged_word = new_data;
      default: merged_word = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one byte/half/word request at a time, drives a
// word-addressed memory and does read-modify-write for sub-word stores.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int MEM_WORDS = 32,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_error,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(MEM_WORDS * 4);

  state_e            state_r;
  size_e             size_r;
  size_e             req_size_s;
  logic              unsigned_r;
  logic [1:0]        offset_r;
  logic [31:0]       wdata_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic              mem_read_r;
  logic              mem_write_r;
  logic [31:0]       mem_wdata_r;
  logic              resp_valid_r;
  logic              resp_error_r;
  logic [31:0]       resp_rdata_r;
  logic              req_bad_s;
  logic [31:0]       load_data_s;
  logic [31:0]       merged_s;

  assign req_size_s = size_e'(req_size);

  // Classify the incoming request as bad before it is accepted.
  always_comb begin
    req_bad_s = 1'b0;
    if (req_addr >= ADDR_LIMIT) begin
      req_bad_s = 1'b1;
    end else begin
      req_bad_s = is_bad_shape(req_size_s, req_addr[1:0]);
    end
  end

  load_store_unit_lane_align u_lane_align (
    .word        (mem_rdata),
    .offset      (offset_r),
    .size        (size_r),
    .is_unsigned (unsigned_r),
    .new_data    (wdata_r),
    .load_data   (load_data_s),
    .merged_word (merged_s)
  );

  // Request FSM with registered strobes and response; strobes are set on entry
  // to the state that owns them so each lasts exactly one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      size_r       <= SZ_BYTE;
      unsigned_r   <= 1'b0;
      offset_r     <= 2'b00;
      wdata_r      <= 32'h0000_0000;
      mem_addr_r   <= '0;
      mem_read_r   <= 1'b0;
      mem_write_r  <= 1'b0;
      mem_wdata_r  <= 32'h0000_0000;
      resp_valid_r <= 1'b0;
      resp_error_r <= 1'b0;
      resp_rdata_r <= 32'h0000_0000;
    end else begin
      mem_read_r   <= 1'b0;
      mem_write_r  <= 1'b0;
      resp_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            size_r     <= req_size_s;
            unsigned_r <= req_unsigned;
            offset_r   <= req_addr[1:0];
            wdata_r    <= req_wdata;
            mem_addr_r <= {req_addr[ADDR_W-1:2], 2'b00};
            if (req_bad_s) begin
              state_r      <= ST_DONE;
              resp_valid_r <= 1'b1;
              resp_error_r <= 1'b1;
              resp_rdata_r <= 32'h0000_0000;
            end else if (!req_write) begin
              state_r    <= ST_READ;
              mem_read_r <= 1'b1;
            end else if (req_size_s == SZ_WORD) begin
              state_r     <= ST_WRITE;
              mem_write_r <= 1'b1;
              mem_wdata_r <= req_wdata;
            end else begin
              state_r    <= ST_RMW_READ;
              mem_read_r <= 1'b1;
            end
          end
        end
        ST_READ: begin
          state_r      <= ST_DONE;
          resp_valid_r <= 1'b1;
          resp_error_r <= 1'b0;
          resp_rdata_r <= load_data_s;
        end
        ST_WRITE: begin
          state_r      <= ST_DONE;
          resp_valid_r <= 1'b1;
          resp_error_r <= 1'b0;
          resp_rdata_r <= 32'h0000_0000;
        end
        ST_RMW_READ: begin
          state_r     <= ST_RMW_WRITE;
          mem_write_r <= 1'b1;
          mem_wdata_r <= merged_s;
        end
        ST_RMW_WRITE: begin
          state_r      <= ST_DONE;
          resp_valid_r <= 1'b1;
          resp_error_r <= 1'b0;
          resp_rdata_r <= 32'h0000_0000;
        end
        ST_DONE: begin
          state_r      <= ST_IDLE;
          resp_error_r <= 1'b0;
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = (state_r == ST_IDLE) && !reset;
  assign resp_valid = resp_valid_r;
  assign resp_error = resp_error_r;
  assign resp_rdata = resp_rdata_r;
  assign mem_addr   = mem_addr_r;
  assign mem_read   = mem_read_r;
  assign mem_write  = mem_write_r;
  assign mem_wdata  = mem_wdata_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, randomized requests checked
// against a word-array reference model, and a reset-during-RMW sequence.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  load_store_unit #(.MEM_WORDS(32), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_error(resp_error), .mem_addr(mem_addr),
    .mem_read(mem_read), .mem_write(mem_write), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Attached memory: 32 words, combinational read, write on rising edge.
  logic [31:0] mem [0:31];
  logic        mem_clr = 1'b1;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
    end else if (mem_write) begin
      mem[mem_addr[6:2]] <= mem_wdata;
    end
  end
  assign mem_rdata = mem_read ? mem[mem_addr[6:2]] : 32'h0;

  // Strobe monitor for the transaction in flight.
  int          n_rd, n_wr, n_both, n_addr_bad;
  logic [31:0] mon_exp_addr;
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_read) n_rd++;
      if (mem_write) n_wr++;
      if (mem_read && mem_write) n_both++;
      if ((mem_read || mem_write) && mem_addr != mon_exp_addr) n_addr_bad++;
    end
  end

  // Reference model: plain word array updated by the architectural rules.
  logic [31:0] ref_mem [0:31];

  function automatic void model(input bit wr, input bit [1:0] sz, input bit un,
                                input bit [31:0] a, input bit [31:0] wd,
                                output bit [31:0] er, output bit ee, output int el,
                                output int erd, output int ewr);
    int idx, sh;
    bit [31:0] w, lane, mask;
    ee = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) || (a >= 32'd128);
    er = 32'h0; erd = 0; ewr = 0; el = 1;
    if (ee) return;
    idx = int'(a / 32'd4);
    sh  = int'(a % 32'd4) * 8;
    w   = ref_mem[idx];
    if (!wr) begin
      el = 2; erd = 1;
      if (sz == 2'd0) begin
        lane = (w >> sh) & 32'hFF;
        if (!un && lane[7]) lane = lane | 32'hFFFF_FF00;
      end else if (sz == 2'd1) begin
        lane = (w >> sh) & 32'hFFFF;
        if (!un && lane[15]) lane = lane | 32'hFFFF_0000;
      end else begin
        lane = w;
      end
      er = lane;
    end else begin
      ewr = 1;
      if (sz == 2'd2) begin
        el = 2;
        ref_mem[idx] = wd;
      end else begin
        el = 3; erd = 1;
        mask = (sz == 2'd0) ? 32'hFF : 32'hFFFF;
        ref_mem[idx] = (w & ~(mask << sh)) | ((wd & mask) << sh);
      end
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // Issue one request and check response, latency and strobe behaviour.
  task automatic apply(input string nm, input bit wr, input bit [1:0] sz, input bit un,
                       input bit [31:0] a, input bit [31:0] wd,
                       input bit [31:0] er, input bit ee, input int el,
                       input int erd, input int ewr);
    int lat;
    logic [31:0] held;
    @(negedge clk);
    chk({nm, ".ready"}, {31'h0, req_ready}, 32'd1);
    req_write = wr; req_size = sz; req_unsigned = un; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    n_rd = 0; n_wr = 0; n_both = 0; n_addr_bad = 0;
    mon_exp_addr = {a[31:2], 2'b00};
    #1 req_valid = 1'b0;
    lat = 0;
    while (lat < 8) begin
      @(negedge clk);
      lat++;
      if (resp_valid) break;
    end
    if (!resp_valid) lat = 99;
    chk({nm, ".latency"}, lat, el);
    chk({nm, ".error"}, {31'h0, resp_error}, {31'h0, ee});
    chk({nm, ".rdata"}, resp_rdata, er);
    chk({nm, ".reads"}, n_rd, erd);
    chk({nm, ".writes"}, n_wr, ewr);
    chk({nm, ".overlap"}, n_both, 32'd0);
    chk({nm, ".addr"}, n_addr_bad, 32'd0);
    held = resp_rdata;
    @(negedge clk);
    chk({nm, ".pulse"}, {31'h0, resp_valid}, 32'd0);
    chk({nm, ".hold"}, resp_rdata, held);
  endtask

  typedef struct {
    bit        wr;
    bit [1:0]  sz;
    bit        un;
    bit [31:0] a;
    bit [31:0] wd;
    bit [31:0] er;
    bit        ee;
    int        el;
  } vec_t;

  vec_t vt [16];

  initial begin
    bit [31:0] er, a, wd;
    bit        ee, wr, un;
    bit [1:0]  sz;
    int        el, erd, ewr;

    for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;

    //              wr    sz     un    addr       wdata          rdata          err  lat
    vt[0]  = '{1'b1, 2'd2, 1'b0, 32'h08, 32'hDEADBEEF, 32'h0,         1'b0, 2};
    vt[1]  = '{1'b0, 2'd2, 1'b0, 32'h08, 32'h0,        32'hDEADBEEF,  1'b0, 2};
    vt[2]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, 32'h0,         1'b0, 2};
    vt[3]  = '{1'b1, 2'd0, 1'b0, 32'h12, 32'h123456AA, 32'h0,         1'b0, 3};
    vt[4]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'h11AA3344,  1'b0, 2};
    vt[5]  = '{1'b0, 2'd0, 1'b0, 32'h12, 32'h0,        32'hFFFFFFAA,  1'b0, 2};
    vt[6]  = '{1'b0, 2'd0, 1'b1, 32'h12, 32'h0,        32'h000000AA,  1'b0, 2};
    vt[7]  = '{1'b0, 2'd1, 1'b0, 32'h10, 32'h0,        32'h00003344,  1'b0, 2};
    vt[8]  = '{1'b0, 2'd2, 1'b0, 32'h06, 32'h0,        32'h0,         1'b1, 1};
    vt[9]  = '{1'b1, 2'd1, 1'b0, 32'h03, 32'h5555,     32'h0,         1'b1, 1};
    vt[10] = '{1'b0, 2'd2, 1'b0, 32'h80, 32'h0,        32'h0,         1'b1, 1};
    vt[11] = '{1'b1, 2'd2, 1'b0, 32'h7C, 32'hCAFEF00D, 32'h0,         1'b0, 2};
    vt[12] = '{1'b0, 2'd2, 1'b0, 32'h7C, 32'h0,        32'hCAFEF00D,  1'b0, 2};
    vt[13] = '{1'b0, 2'd3, 1'b0, 32'h04, 32'h0,        32'h0,         1'b1, 1};
    vt[14] = '{1'b1, 2'd1, 1'b0, 32'h12, 32'h00008001, 32'h0,         1'b0, 3};
    vt[15] = '{1'b0, 2'd1, 1'b0, 32'h12, 32'h0,        32'hFFFF8001,  1'b0, 2};

    // Reset state.
    #1;
    chk("rst.ready", {31'h0, req_ready}, 32'd0);
    chk("rst.valid", {31'h0, resp_valid}, 32'd0);
    chk("rst.strobes", {30'h0, mem_read, mem_write}, 32'd0);
    chk("rst.addr", mem_addr, 32'd0);
    chk("rst.rdata", resp_rdata, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    mem_clr = 1'b0;
    reset = 1'b0;
    #1 chk("rst.ready_after", {31'h0, req_ready}, 32'd1);

    // Directed table; the model tracks memory and supplies strobe counts.
    for (int i = 0; i < 16; i++) begin
      model(vt[i].wr, vt[i].sz, vt[i].un, vt[i].a, vt[i].wd, er, ee, el, erd, ewr);
      apply($sformatf("vec%0d", i), vt[i].wr, vt[i].sz, vt[i].un, vt[i].a, vt[i].wd,
            vt[i].er, vt[i].ee, vt[i].el, erd, ewr);
    end

    // Reset during RMW_READ: strobes drop at once, no response, memory untouched.
    @(negedge clk);
    req_write = 1'b1; req_size = 2'd0; req_addr = 32'h11; req_wdata = 32'h55;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rmwrst.read_seen", {31'h0, mem_read}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rmwrst.read_drop", {31'h0, mem_read}, 32'd0);
    chk("rmwrst.write_drop", {31'h0, mem_write}, 32'd0);
    chk("rmwrst.ready", {31'h0, req_ready}, 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("rmwrst.no_resp", {31'h0, resp_valid}, 32'd0);
    end
    reset = 1'b0;
    #1 chk("rmwrst.ready_after", {31'h0, req_ready}, 32'd1);
    chk("rmwrst.mem_kept", mem[4], ref_mem[4]);
    model(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, er, ee, el, erd, ewr);
    apply("rmwrst.reload", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, er, ee, el, erd, ewr);

    // Randomized requests against the reference model.
    for (int i = 0; i < 80; i++) begin
      wr = 1'($urandom_range(0, 1));
      un = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a  = ($urandom_range(0, 9) == 0) ? $urandom_range(128, 300) : $urandom_range(0, 127);
      if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
      wd = $urandom;
      model(wr, sz, un, a, wd, er, ee, el, erd, ewr);
      apply($sformatf("rnd%0d", i), wr, sz, un, a, wd, er, ee, el, erd, ewr);
    end

    // Final memory image must match the model.
    for (int i = 0; i < 32; i++) chk($sformatf("mem%0d", i), mem[i], ref_mem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
